// File: rtl/chan_sel_bin_extract.sv
// Picks one channel out of the time-multiplexed channelizer stream and emits one sample per frame.
// Optional build macro CHAN_SEL_TIMESTAMP_EN adds the frame_cnt and ts_out outputs.
module chan_sel_bin_extract #(
    parameter int N_CHAN  = 256,
    parameter int CHAN_W  = 8,
    parameter int DATA_W  = 32,
    parameter int FRAME_W = 32
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ch_bin,
    input  logic              sync_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_vld_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld_out,
    output logic [CHAN_W-1:0] cur_bin,
    output logic              locked,
`ifdef CHAN_SEL_TIMESTAMP_EN
    output logic [FRAME_W-1:0] frame_cnt,
    output logic [FRAME_W-1:0] ts_out,
`endif
    output logic              sync_err
);

    // Handshake: a sample moves only on cycles with data_vld_in=1 (a beat); there is no
    // backpressure. data_vld_out is a one-cycle strobe qualifying data_out.

    typedef enum logic {WAIT_SYNC = 1'b0, RUN = 1'b1} state_t;

    logic [1:0]        rst_pipe;
    logic              rst_n;
    state_t            state, state_nxt;
    logic [CHAN_W-1:0] chan_cnt, cnt_nxt;
    logic [CHAN_W-1:0] bin_nxt, eff_chan;
    logic              en_q, en_nxt;
    logic              err_nxt;
    logic              relatch, run_sync, sel;
    logic              unused_ch_bin;

    assign unused_ch_bin = ^ch_bin[30:CHAN_W];

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) rst_pipe <= 2'b00;
        else             rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_SYNC;
            chan_cnt     <= '0;
            cur_bin      <= '0;
            en_q         <= 1'b0;
            sync_err     <= 1'b0;
            data_out     <= '0;
            data_vld_out <= 1'b0;
        end else begin
            state        <= state_nxt;
            chan_cnt     <= cnt_nxt;
            cur_bin      <= bin_nxt;
            en_q         <= en_nxt;
            sync_err     <= err_nxt;
            data_vld_out <= sel;
            if (sel) data_out <= data_in;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = chan_cnt;
        bin_nxt   = cur_bin;
        en_nxt    = en_q;
        err_nxt   = sync_err;
        eff_chan  = chan_cnt;
        relatch   = 1'b0;
        run_sync  = 1'b0;
        case (state)
            WAIT_SYNC: begin
                if (data_vld_in && sync_in) begin
                    state_nxt = RUN;
                    relatch   = 1'b1;
                    eff_chan  = '0;
                    cnt_nxt   = CHAN_W'(1);
                end
            end
            RUN: begin
                if (data_vld_in) begin
                    if (sync_in) begin
                        // A sync beat is always channel 0, even when it arrives early.
                        relatch  = 1'b1;
                        run_sync = 1'b1;
                        eff_chan = '0;
                        cnt_nxt  = CHAN_W'(1);
                        if (chan_cnt != '0) err_nxt = 1'b1;
                    end else begin
                        cnt_nxt = (chan_cnt == CHAN_W'(N_CHAN - 1)) ? '0 : chan_cnt + CHAN_W'(1);
                    end
                end
            end
            default: state_nxt = WAIT_SYNC;
        endcase
        if (relatch) begin
            bin_nxt = ch_bin[CHAN_W-1:0];
            en_nxt  = ch_bin[31];
        end
        // The sync beat selects against the bin latched on that same beat.
        sel = data_vld_in && ((state == RUN) || relatch) && en_nxt && (eff_chan == bin_nxt);
    end

    assign locked = (state == RUN);

`ifdef CHAN_SEL_TIMESTAMP_EN
    logic [FRAME_W-1:0] fc_nxt;

    assign fc_nxt = run_sync ? frame_cnt + FRAME_W'(1) : frame_cnt;

    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            ts_out    <= '0;
        end else begin
            frame_cnt <= fc_nxt;
            if (sel) ts_out <= fc_nxt;
        end
    end
`else
    logic unused_run_sync;
    assign unused_run_sync = run_sync;
`endif

endmodule

// File: tb/tb_chan_sel_bin_extract.sv
// Self-checking bench for chan_sel_bin_extract: a beat-level reference model pushes expected
// samples into a queue, and a monitor pops and compares them on every output strobe.
module tb_chan_sel_bin_extract;

    localparam int N_CHAN  = 256;
    localparam int CHAN_W  = 8;
    localparam int DATA_W  = 32;
    localparam int FRAME_W = 32;

    logic              user_clk = 1'b0;
    logic              user_rst_n = 1'b0;
    logic [31:0]       ch_bin = '0;
    logic              sync_in = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_vld_in = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              data_vld_out;
    logic [CHAN_W-1:0] cur_bin;
    logic              locked;
    logic              sync_err;
`ifdef CHAN_SEL_TIMESTAMP_EN
    logic [FRAME_W-1:0] frame_cnt;
    logic [FRAME_W-1:0] ts_out;
`endif

    chan_sel_bin_extract #(
        .N_CHAN(N_CHAN), .CHAN_W(CHAN_W), .DATA_W(DATA_W), .FRAME_W(FRAME_W)
    ) dut (
        .user_clk    (user_clk),
        .user_rst_n  (user_rst_n),
        .ch_bin      (ch_bin),
        .sync_in     (sync_in),
        .data_in     (data_in),
        .data_vld_in (data_vld_in),
        .data_out    (data_out),
        .data_vld_out(data_vld_out),
        .cur_bin     (cur_bin),
        .locked      (locked),
`ifdef CHAN_SEL_TIMESTAMP_EN
        .frame_cnt   (frame_cnt),
        .ts_out      (ts_out),
`endif
        .sync_err    (sync_err)
    );

    // clock / reset
    always #5 user_clk = ~user_clk;

    int cyc = 0;
    always @(posedge user_clk) cyc++;

    // scoreboard state
    logic [DATA_W-1:0]  exp_q[$];
    int                 exp_cyc_q[$];
    logic [FRAME_W-1:0] exp_ts_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int strobe_cnt = 0;

    // reference model state
    bit              m_locked = 1'b0;
    int              m_cnt = 0;
    logic [CHAN_W-1:0] m_bin = '0;
    bit              m_en = 1'b0;
    bit              m_err = 1'b0;
    logic [FRAME_W-1:0] m_fc = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge user_clk) begin
        if (data_vld_out === 1'b1) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_strobe", 64'(exp_q.size() != 0), 64'd1);
            end else begin
                check_val("data_out", data_out, exp_q.pop_front());
                check_val("strobe_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
`ifdef CHAN_SEL_TIMESTAMP_EN
                check_val("ts_out", ts_out, exp_ts_q.pop_front());
`else
                void'(exp_ts_q.pop_front());
`endif
            end
        end
    end

    // driver: present one cycle of input and advance the model for beats
    task automatic beat(input logic vld, input logic sync, input logic [DATA_W-1:0] d);
        bit consider;
        int ch;
        @(posedge user_clk);
        #1;
        data_vld_in = vld;
        sync_in     = sync;
        data_in     = d;
        if (!vld) return;
        consider = 1'b0;
        ch = 0;
        if (sync) begin
            if (m_locked && m_cnt != 0) m_err = 1'b1;
            if (m_locked) m_fc = m_fc + 1;
            m_locked = 1'b1;
            m_bin    = ch_bin[CHAN_W-1:0];
            m_en     = ch_bin[31];
            m_cnt    = 1;
            consider = 1'b1;
        end else if (m_locked) begin
            ch       = m_cnt;
            m_cnt    = (m_cnt + 1) % N_CHAN;
            consider = 1'b1;
        end
        if (consider && m_en && ch == int'(m_bin)) begin
            exp_q.push_back(d);
            exp_cyc_q.push_back(cyc + 1);
            exp_ts_q.push_back(m_fc);
        end
    endtask

    task automatic idle_and_check(input string tag);
        @(posedge user_clk);
        #1;
        data_vld_in = 1'b0;
        sync_in     = 1'b0;
        #1;
        check_val({tag, "_cur_bin"}, cur_bin, m_bin);
        check_val({tag, "_locked"}, locked, m_locked);
        check_val({tag, "_sync_err"}, sync_err, m_err);
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_cnt = 0; m_bin = '0; m_en = 1'b0; m_err = 1'b0; m_fc = '0;
        exp_q.delete(); exp_cyc_q.delete(); exp_ts_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_data_out"}, data_out, 0);
        check_val({tag, "_data_vld_out"}, data_vld_out, 0);
        check_val({tag, "_cur_bin"}, cur_bin, 0);
        check_val({tag, "_locked"}, locked, 0);
        check_val({tag, "_sync_err"}, sync_err, 0);
`ifdef CHAN_SEL_TIMESTAMP_EN
        check_val({tag, "_frame_cnt"}, frame_cnt, 0);
        check_val({tag, "_ts_out"}, ts_out, 0);
`endif
    endtask

    task automatic release_reset();
        @(posedge user_clk);
        #1 user_rst_n = 1'b1;
        repeat (4) @(posedge user_clk);
    endtask

    initial begin
        int s0;
        // reset state
        #22;
        check_all_zero("reset");
        release_reset();

        // lock and select: bin 5, data = beat index
        ch_bin = 32'h8000_0005;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < N_CHAN; i++) beat(1'b1, i == 0, DATA_W'(f * N_CHAN + i));
        idle_and_check("lock");

        // bin change mid-frame takes effect at next sync
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < N_CHAN; i++) begin
                if (f == 0 && i == 100) begin
                    ch_bin = 32'h8000_0010;
                    idle_and_check("bin_mid");
                end
                beat(1'b1, i == 0, $urandom);
            end
        idle_and_check("bin_new");

        // misaligned sync at chan_cnt 37 with bin 5, then with bin 0
        ch_bin = 32'h8000_0005;
        for (int i = 0; i < 37; i++) beat(1'b1, i == 0, $urandom);
        beat(1'b1, 1'b1, $urandom);
        for (int i = 1; i < 10; i++) beat(1'b1, 1'b0, $urandom);
        idle_and_check("misalign1");
        ch_bin = 32'h8000_0000;
        beat(1'b1, 1'b1, $urandom);
        for (int i = 1; i < N_CHAN; i++) beat(1'b1, 1'b0, $urandom);
        ch_bin = 32'h8000_0007;
        for (int i = 0; i < N_CHAN; i++) beat(1'b1, i == 0, $urandom);
        idle_and_check("misalign_sticky");

        // enable off for 3 frames
        ch_bin = 32'h0000_0003;
        s0 = strobe_cnt;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < N_CHAN; i++) beat(1'b1, i == 0, $urandom);
        idle_and_check("en_off");
        repeat (2) @(posedge user_clk);
        check_val("en_off_strobes", 64'(strobe_cnt - s0), 64'd0);

        // bin 255 with gapped input, then the next frame's sync
        ch_bin = 32'h8000_00FF;
        s0 = strobe_cnt;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < N_CHAN; i++) begin
                beat(1'b1, i == 0, $urandom);
                beat(1'b0, 1'b0, $urandom);
            end
        beat(1'b1, 1'b1, $urandom);
        idle_and_check("bin255");
        repeat (2) @(posedge user_clk);
        check_val("bin255_strobes", 64'(strobe_cnt - s0), 64'd2);

        // reset mid-frame
        ch_bin = 32'h8000_0005;
        for (int i = 0; i < 50; i++) beat(1'b1, i == 0, $urandom);
        @(posedge user_clk);
        #1 data_vld_in = 1'b0;
        #2 user_rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("mid_reset");
        repeat (2) @(posedge user_clk);
        release_reset();
        s0 = strobe_cnt;
        for (int i = 0; i < 20; i++) beat(1'b1, 1'b0, $urandom);
        idle_and_check("post_reset");
        repeat (2) @(posedge user_clk);
        check_val("post_reset_strobes", 64'(strobe_cnt - s0), 64'd0);

        // 4 frames on bin 2 from a fresh lock (timestamps 0..3 when built in)
        ch_bin = 32'h8000_0002;
        s0 = strobe_cnt;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < N_CHAN; i++) beat(1'b1, i == 0, $urandom);
        idle_and_check("ts");
        repeat (2) @(posedge user_clk);
        check_val("ts_strobes", 64'(strobe_cnt - s0), 64'd4);

        repeat (4) @(posedge user_clk);
        check_val("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
